// File: rtl/stream_upsizer_pkg.sv
// rtl/stream_upsizer_pkg.sv - shared stream helpers: default widths, counter sizing, lane offsets
package stream_upsizer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_RATIO      = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((int'(1) << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int lane_offset(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow ready/valid beats into one wide word, last flushes early
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RATIO      = DEFAULT_RATIO
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          last_in,
    output logic                          ready_out,
    output logic                          valid_out,
    output logic [DATA_WIDTH*RATIO-1:0]   data_out,
    output logic [RATIO-1:0]              keep_out,
    output logic                          last_out,
    input  logic                          ready_in
);

    localparam int LANE_W = DATA_WIDTH;
    localparam int WORD_W = DATA_WIDTH * RATIO;
    localparam int CNT_W  = clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [RATIO-1:0]  mask_q, mask_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]  out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic [WORD_W-1:0] acc_merged;
    logic [RATIO-1:0]  mask_merged;
    logic              beat_fire;
    logic              word_fire;
    logic              complete;

    // Stall only while a word is held and not being taken this cycle.
    assign ready_out = ~reset & (~out_valid_q | ready_in);
    assign beat_fire = valid_in & ready_out;
    assign word_fire = out_valid_q & ready_in;
    assign complete  = beat_fire & ((cnt_q == LAST_LANE) | last_in);

    always_comb begin
        acc_merged = acc_q;
        mask_merged = mask_q;
        acc_merged[lane_offset(int'(cnt_q), LANE_W) +: LANE_W] = data_in;
        mask_merged[cnt_q] = 1'b1;
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (beat_fire) begin
            if (complete) begin
                cnt_d  = '0;
                acc_d  = '0;
                mask_d = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                acc_d  = acc_merged;
                mask_d = mask_merged;
            end
        end

        // A completing beat reloads the output even while it drains, so no bubble appears.
        if (complete) begin
            out_data_d  = acc_merged;
            out_keep_d  = mask_merged;
            out_last_d  = last_in;
            out_valid_d = 1'b1;
        end else if (word_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            mask_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign valid_out = out_valid_q;
    assign data_out  = out_data_q;
    assign keep_out  = out_keep_q;
    assign last_out  = out_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - scoreboard bench for stream_upsizer with directed beat vectors
module tb_stream_upsizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        last_in;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_in;

    stream_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t exp_q[$];
    word_t mon_e;
    int n_cmp = 0;
    int n_fail = 0;
    int cycle = 0;
    int words_seen = 0;
    int beats_acc = 0;
    int vo_cycles = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every word handshake.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (valid_in && ready_out) beats_acc++;
            if (valid_out) vo_cycles++;
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h, expected no word", data_out, keep_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", data_out, mon_e.data);
                    check("word_keep", 32'(keep_out), 32'(mon_e.keep));
                    check("word_last", 32'(last_out), 32'(mon_e.last));
                    words_seen++;
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        @(negedge clk);
        while (!ready_out && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: beat 0x%0h not accepted, required acceptance within 200 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int start;

        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        last_in  = 1'b0;
        ready_in = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_keep_out", 32'(keep_out), 32'h0);
        check("rst_last_out", 32'(last_out), 32'h0);
        check("rst_ready_out", 32'(ready_out), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(ready_out), 32'h1);

        // Full word, latency one cycle, valid for exactly one cycle.
        push_word(32'h44332211, 4'b1111, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        idle();
        check("full_latency_valid", 32'(valid_out), 32'h1);
        wait_cycles(1);
        check("full_one_cycle", 32'(valid_out), 32'h0);

        // Early last, then a single-beat packet at lane 0.
        push_word(32'h0000BBAA, 4'b0011, 1'b1);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        push_word(32'h0000005C, 4'b0001, 1'b1);
        send_beat(8'h5C, 1'b1);
        idle();
        wait_cycles(2);

        // Backpressure with a second word queued upstream.
        ready_in = 1'b0;
        push_word(32'h04030201, 4'b1111, 1'b0);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        idle();
        check("bp_ready_drop", 32'(ready_out), 32'h0);
        push_word(32'h08070605, 4'b1111, 1'b0);
        base = beats_acc;
        fork
            begin
                send_beat(8'h05, 1'b0);
                send_beat(8'h06, 1'b0);
                send_beat(8'h07, 1'b0);
                send_beat(8'h08, 1'b0);
                idle();
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_ready_low", 32'(ready_out), 32'h0);
                    check("bp_data_stable", data_out, 32'h04030201);
                    check("bp_valid_held", 32'(valid_out), 32'h1);
                end
                check("bp_no_accept", 32'(beats_acc - base), 32'h0);
                @(posedge clk);
                #1;
                ready_in = 1'b1;
                #1;
                check("bp_ready_recover", 32'(ready_out), 32'h1);
            end
        join
        wait_cycles(3);
        check("bp_beats_total", 32'(beats_acc - base), 32'h4);

        // Continuous stream: 12 beats in 12 cycles, three words.
        push_word(32'h13121110, 4'b1111, 1'b0);
        push_word(32'h17161514, 4'b1111, 1'b0);
        push_word(32'h1B1A1918, 4'b1111, 1'b0);
        start = cycle;
        for (int i = 0; i < 12; i++) begin
            send_beat(8'h10 + 8'(i), 1'b0);
        end
        idle();
        check("stream_throughput", 32'(cycle - start), 32'd12);
        wait_cycles(3);

        // Back-to-back single-beat packets: drain and completion coincide.
        push_word(32'h000000E1, 4'b0001, 1'b1);
        push_word(32'h000000E2, 4'b0001, 1'b1);
        push_word(32'h000000E3, 4'b0001, 1'b1);
        base = vo_cycles;
        send_beat(8'hE1, 1'b1);
        send_beat(8'hE2, 1'b1);
        send_beat(8'hE3, 1'b1);
        idle();
        check("no_bubble_valid", 32'(valid_out), 32'h1);
        wait_cycles(3);
        check("no_bubble_vo_cycles", 32'(vo_cycles - base), 32'd3);

        // Reset mid-word discards the partial word.
        send_beat(8'h77, 1'b0);
        send_beat(8'h88, 1'b0);
        idle();
        reset = 1'b1;
        #1;
        check("midrst_ready_low", 32'(ready_out), 32'h0);
        @(posedge clk);
        #1;
        check("midrst_valid_out", 32'(valid_out), 32'h0);
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_keep_out", 32'(keep_out), 32'h0);
        check("midrst_last_out", 32'(last_out), 32'h0);
        reset = 1'b0;
        push_word(32'h0D0C0B0A, 4'b1111, 1'b0);
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0B, 1'b0);
        send_beat(8'h0C, 1'b0);
        send_beat(8'h0D, 1'b0);
        idle();
        wait_cycles(3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        check("words_seen", 32'(words_seen), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_upsizer.md
# stream_upsizer

Width-up converter for the team's ready/valid streams: packs RATIO consecutive narrow beats into one wide word, with a `last` flag that flushes partial words early. Sits directly downstream of the team's narrow-side register/skid slices and feeds wide-datapath consumers. Both sides use the same valid/ready handshake, and the block sustains one narrow beat per cycle at full throughput.

## Interface
- DATA_WIDTH, 8, narrow beat width in bits.
- RATIO, 4, narrow beats per wide word; must be ≥2.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- valid_in  input  1  upstream beat valid.
- data_in  input  DATA_WIDTH  upstream beat data.
- last_in  input  1  beat is the final one of a packet; closes the current word.
- ready_out  output  1  block accepts a beat this cycle.
- valid_out  output  1  wide word valid.
- data_out  output  DATA_WIDTH*RATIO  wide word; beat i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- keep_out  output  RATIO  lane i holds a real beat.
- last_out  output  1  word ends a packet.
- ready_in  input  1  downstream accepts the wide word.

## Operation
- Handshakes:
  - A beat transfers when `valid_in & ready_out`.
  - A word transfers when `valid_out & ready_in`.
- State:
  - Accumulator `acc` (RATIO lanes).
  - Lane counter `cnt` (clog2(RATIO) bits, 0..RATIO-1).
  - Per-lane fill mask.
  - Output register: data, keep, last, out_valid.
- Accepted beat: written to lane `cnt`, its mask bit set.
  - If `cnt==RATIO-1` or `last_in`, the word completes. Otherwise `cnt` increments.
- Word completion: in the same edge, the output register loads `acc` with the new beat merged in, keep = mask with the new bit, last = `last_in`, out_valid = 1.
  - `acc`, mask and `cnt` then clear to 0.
  - Unfilled lanes of data_out are 0.
- Flow control: `ready_out = ~reset & (~out_valid | ready_in)`.
  - Applies uniformly to every beat, not only completing beats.
  - ready_in→ready_out is a permitted combinational path.
- Output stability: while `valid_out & ~ready_in`, data_out, keep_out and last_out hold stable, and valid_out stays 1.
- Output draining: word handshake with no completion in the same cycle → out_valid clears.
- Simultaneous drain and completion: the output register reloads and valid_out stays 1. There is no bubble.
- `last_in` on lane 0: emits a one-lane word, keep_out = 0…01.
- Both RATIO wrap and `last_in` on the same beat: emits a full word with last_out = 1.

## Timing
- Reset values: valid_out 0, data_out 0, keep_out 0, last_out 0, `cnt` 0, `acc`/mask 0. ready_out is 0 while reset is high and 1 on the first cycle after reset.
- Reset mid-word: the partial word and any pending output word are discarded, with no flush.
- Latency: valid_out asserts the cycle after the completing beat's handshake.
- Throughput: 1 narrow beat/cycle, sustained when ready_in is held high.
- Backpressure: ready_out falls in the same cycle that out_valid & ~ready_in, and recovers in the same cycle that ready_in rises.
- Handshake input rules:
  - valid_in may assert regardless of ready_out.
  - Upstream holds data_in/last_in stable until accepted.
  - Downstream may toggle ready_in freely.

## Structure
- Shared stream package:
  - clog2 helper for counter width.
  - Lane index/offset macros or localparams (LANE_W = DATA_WIDTH, WORD_W = DATA_WIDTH*RATIO).
- No sub-module: the accumulator and output register are a single always block plus continuous assigns.
- Deeper downstream decoupling is done by instantiating the team's existing slice on the wide side, outside this block.

## Test plan
- Full words: DATA_WIDTH=8, RATIO=4, ready_in=1, beats 0x11,0x22,0x33,0x44 back-to-back → data_out=0x44332211, keep_out=4'b1111, last_out=0, valid_out for exactly one cycle, one cycle after the 0x44 handshake.
- Early last: beats 0xAA, 0xBB with last_in on 0xBB → data_out=0x0000BBAA, keep_out=4'b0011, last_out=1; next word starts at lane 0.
- Single-beat packet: 0x5C with last_in at lane 0 → keep_out=4'b0001, data_out=0x0000005C, last_out=1.
- Backpressure:
  - Setup: ready_in=0 while a word is pending and a second word is streamed in.
  - ready_out: drops immediately; no beat is accepted.
  - Output: data_out is stable across 5 stall cycles.
  - On ready_in rising: ready_out=1 the same cycle, the word drains, and 8 beats in total yield 2 correct words with no loss or duplication.
- Simultaneous drain/complete: continuous stream with ready_in=1 → valid_out high every 4th cycle and never dropped between adjacent words, even when a word handshake coincides with a completing beat.
- Reset mid-word: 2 beats accepted, then reset for 1 cycle → all outputs 0, ready_out=0 during reset; next 4 beats form a clean word with keep_out=4'b1111 and no stale lanes.
